// File: rtl/execute_stage_m.sv
// RV32I/RV32M execute stage: forwarding, handshaked output register and an
// iterative radix-2 multiply/divide unit that stalls the pipeline while busy.
module execute_stage_m #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ENABLE_M   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [XLEN-1:0]       imm,
    input  logic [6:0]            opcode,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    input  logic [4:0]            rs1_num,
    input  logic [4:0]            rs2_num,
    input  logic [4:0]            rd_num,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic                  fwd_mem_en,
    input  logic [4:0]            fwd_mem_num,
    input  logic [XLEN-1:0]       fwd_mem_data,
    input  logic                  fwd_wb_en,
    input  logic [4:0]            fwd_wb_num,
    input  logic [XLEN-1:0]       fwd_wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic [XLEN-1:0]       out_store_data,
    output logic [4:0]            out_rd_num,
    output logic [2:0]            out_func3,
    output logic [3:0]            out_state,
    output logic                  pc_write_enable,
    output logic [ADDR_WIDTH-1:0] pc_write_data,
    output logic                  busy
);
    localparam int SW = $clog2(XLEN);
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [3:0] ST_IDLE = 4'd0, ST_REG = 4'd1, ST_LOAD = 4'd2;
    localparam logic [3:0] ST_STORE = 4'd3, ST_PCW = 4'd4, ST_PCSEL = 4'd5;
    localparam logic [3:0] ST_LUI = 4'd6;

    typedef enum logic [1:0] {S_IDLE, S_MULDIV, S_DONE} fsm_t;
    fsm_t r_fsm;

    logic [XLEN-1:0] r_res, r_sd, r_hi, r_lo, r_md, r_dvd;
    logic [4:0] r_rd, r_md_rd;
    logic [2:0] r_f3, r_md_f3;
    logic [3:0] r_st;
    logic r_valid, r_pwe, r_busy, r_sa, r_sb, r_dz;
    logic [ADDR_WIDTH-1:0] r_pwd;
    logic [SW-1:0] r_cnt;

    logic [XLEN-1:0] w_a, w_b, w_op2, w_alu, w_res, w_pc_x;
    logic [SW-1:0] w_shamt;
    logic w_alt, w_taken, w_m_enc, w_is_m, w_accept, w_pwe, w_sa, w_sb;
    logic [3:0] w_st;
    logic [ADDR_WIDTH-1:0] w_pwd, w_jsum;

    // x0 never forwards; the memory stage is younger so it wins over writeback
    always_comb begin
        w_a = rs1_data;
        if (rs1_num == 5'd0) w_a = '0;
        else if (fwd_mem_en && fwd_mem_num == rs1_num) w_a = fwd_mem_data;
        else if (fwd_wb_en && fwd_wb_num == rs1_num) w_a = fwd_wb_data;
        w_b = rs2_data;
        if (rs2_num == 5'd0) w_b = '0;
        else if (fwd_mem_en && fwd_mem_num == rs2_num) w_b = fwd_mem_data;
        else if (fwd_wb_en && fwd_wb_num == rs2_num) w_b = fwd_wb_data;
    end

    assign in_ready = (r_fsm == S_IDLE) && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready && !flush;
    assign w_m_enc  = (opcode == OP_R) && (func7 == 7'b0000001);
    assign w_is_m   = w_m_enc && (ENABLE_M != 0);

    assign w_op2   = (opcode == OP_R) ? w_b : imm;
    assign w_shamt = (opcode == OP_R) ? w_b[SW-1:0] : imm[SW-1:0];
    assign w_alt   = (opcode == OP_R) ? func7[5] : imm[10];
    assign w_pc_x  = XLEN'(pc);
    assign w_jsum  = ADDR_WIDTH'(w_a + imm);

    always_comb begin
        w_alu = '0;
        case (func3)
            3'b000: w_alu = (opcode == OP_R && func7[5]) ? w_a - w_op2
                                                         : w_a + w_op2;
            3'b001: w_alu = w_a << w_shamt;
            3'b010: w_alu = XLEN'($signed(w_a) < $signed(w_op2));
            3'b011: w_alu = XLEN'(w_a < w_op2);
            3'b100: w_alu = w_a ^ w_op2;
            3'b101: w_alu = w_alt ? XLEN'($signed(w_a) >>> w_shamt)
                                  : w_a >> w_shamt;
            3'b110: w_alu = w_a | w_op2;
            default: w_alu = w_a & w_op2;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (func3)
            3'b000: w_taken = (w_a == w_b);
            3'b001: w_taken = (w_a != w_b);
            3'b100: w_taken = ($signed(w_a) < $signed(w_b));
            3'b101: w_taken = !($signed(w_a) < $signed(w_b));
            3'b110: w_taken = (w_a < w_b);
            3'b111: w_taken = !(w_a < w_b);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_res = '0;
        w_st  = ST_IDLE;
        w_pwe = 1'b0;
        w_pwd = pc + ADDR_WIDTH'(imm);
        case (opcode)
            OP_R: begin
                w_res = w_m_enc ? '0 : w_alu;
                w_st  = w_m_enc ? ST_IDLE : ST_REG;
            end
            OP_I:  begin w_res = w_alu; w_st = ST_REG; end
            OP_LD: begin w_res = w_a + imm; w_st = ST_LOAD; end
            OP_ST: begin w_res = w_a + imm; w_st = ST_STORE; end
            OP_BR: begin
                w_st  = w_taken ? ST_PCW : ST_IDLE;
                w_pwe = w_taken;
            end
            OP_JAL: begin
                w_res = w_pc_x + XLEN'(4);
                w_st  = ST_PCSEL;
                w_pwe = 1'b1;
            end
            OP_JALR: begin
                w_res = w_pc_x + XLEN'(4);
                w_st  = ST_PCSEL;
                w_pwe = 1'b1;
                w_pwd = w_jsum & {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
            end
            OP_LUI:   begin w_res = imm; w_st = ST_LUI; end
            OP_AUIPC: begin w_res = w_pc_x + imm; w_st = ST_REG; end
            default: ;
        endcase
    end

    // Operands enter the shift/add engine as magnitudes; sign fixed at DONE
    assign w_sa = w_a[XLEN-1] && (func3 == 3'b001 || func3 == 3'b010 ||
                                  func3 == 3'b100 || func3 == 3'b110);
    assign w_sb = w_b[XLEN-1] && (func3 == 3'b001 || func3 == 3'b100 ||
                                  func3 == 3'b110);

    logic [XLEN:0] w_msum, w_rsh, w_diff;
    logic [2*XLEN-1:0] w_prod, w_sprod;
    logic [XLEN-1:0] w_q, w_r, w_md_res;

    assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_md} : '0);
    assign w_rsh   = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_rsh - {1'b0, r_md};
    assign w_prod  = {r_hi, r_lo};
    assign w_sprod = (r_sa ^ r_sb) ? -w_prod : w_prod;
    assign w_q     = (r_sa ^ r_sb) ? -r_lo : r_lo;
    assign w_r     = r_sa ? -r_hi : r_hi;

    always_comb begin
        w_md_res = w_sprod[XLEN-1:0];
        case (r_md_f3)
            3'b000: w_md_res = w_sprod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_md_res = w_sprod[2*XLEN-1:XLEN];
            3'b100, 3'b101: w_md_res = r_dz ? '1 : w_q;
            default: w_md_res = r_dz ? r_dvd : w_r;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm <= S_IDLE;
            r_valid <= 1'b0; r_pwe <= 1'b0; r_busy <= 1'b0;
            r_res <= '0; r_sd <= '0; r_rd <= '0; r_f3 <= '0;
            r_st <= ST_IDLE; r_pwd <= '0; r_cnt <= '0;
            r_hi <= '0; r_lo <= '0; r_md <= '0; r_dvd <= '0;
            r_sa <= 1'b0; r_sb <= 1'b0; r_dz <= 1'b0;
            r_md_rd <= '0; r_md_f3 <= '0;
        end else if (flush) begin
            r_fsm <= S_IDLE;
            r_valid <= 1'b0; r_pwe <= 1'b0; r_busy <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_pwe <= 1'b0;
            if (r_valid && out_ready) r_valid <= 1'b0;
            case (r_fsm)
                S_IDLE: if (w_accept) begin
                    if (w_is_m) begin
                        r_fsm <= S_MULDIV; r_busy <= 1'b1; r_cnt <= '0;
                        r_md_rd <= rd_num; r_md_f3 <= func3;
                        r_sa <= w_sa; r_sb <= w_sb;
                        r_dz <= (w_b == '0); r_dvd <= w_a;
                        r_hi <= '0;
                        if (func3[2]) begin
                            r_lo <= w_sa ? -w_a : w_a;
                            r_md <= w_sb ? -w_b : w_b;
                        end else begin
                            r_lo <= w_sb ? -w_b : w_b;
                            r_md <= w_sa ? -w_a : w_a;
                        end
                    end else begin
                        r_valid <= 1'b1; r_res <= w_res; r_sd <= w_b;
                        r_rd <= rd_num; r_f3 <= func3; r_st <= w_st;
                        r_pwe <= w_pwe; r_pwd <= w_pwd;
                    end
                end
                S_MULDIV: begin
                    if (r_md_f3[2]) begin
                        if (!w_diff[XLEN]) begin
                            r_hi <= w_diff[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b1};
                        end else begin
                            r_hi <= w_rsh[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        {r_hi, r_lo} <= {w_msum, r_lo[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == SW'(XLEN-1)) begin
                        r_fsm <= S_DONE; r_busy <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b1; r_res <= w_md_res; r_st <= ST_REG;
                    r_rd <= r_md_rd; r_f3 <= r_md_f3;
                    r_fsm <= S_IDLE;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign out_valid       = r_valid;
    assign out_result      = r_res;
    assign out_store_data  = r_sd;
    assign out_rd_num      = r_rd;
    assign out_func3       = r_f3;
    assign out_state       = r_st;
    assign pc_write_enable = r_pwe;
    assign pc_write_data   = r_pwd;
    assign busy            = r_busy;
endmodule

// File: tb/tb_execute_stage_m.sv
// Directed bench for execute_stage_m: single-cycle vector table plus
// multi-cycle MUL/DIV, backpressure, flush and reset sequences.
module tb_execute_stage_m;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] pc, imm, rs1_data, rs2_data, fwd_mem_data, fwd_wb_data;
    logic [6:0] opcode, func7;
    logic [2:0] func3, out_func3;
    logic [4:0] rs1_num, rs2_num, rd_num, fwd_mem_num, fwd_wb_num, out_rd_num;
    logic fwd_mem_en, fwd_wb_en, pc_write_enable, busy;
    logic [31:0] out_result, out_store_data, pc_write_data;
    logic [3:0] out_state;

    execute_stage_m dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .imm(imm), .opcode(opcode), .func3(func3), .func7(func7),
        .rs1_num(rs1_num), .rs2_num(rs2_num), .rd_num(rd_num),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_mem_en(fwd_mem_en), .fwd_mem_num(fwd_mem_num),
        .fwd_mem_data(fwd_mem_data),
        .fwd_wb_en(fwd_wb_en), .fwd_wb_num(fwd_wb_num),
        .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data),
        .out_rd_num(out_rd_num), .out_func3(out_func3),
        .out_state(out_state),
        .pc_write_enable(pc_write_enable), .pc_write_data(pc_write_data),
        .busy(busy)
    );

    localparam logic [6:0] OPR = 7'h33, OPI = 7'h13, LD = 7'h03, STO = 7'h23;
    localparam logic [6:0] BR = 7'h63, JAL = 7'h6F, JALR = 7'h67;
    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17;

    typedef struct {
        logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
        logic [4:0] n1, n2;
        logic [31:0] d1, d2, imm, pc;
        logic me; logic [4:0] mn; logic [31:0] md;
        logic we; logic [4:0] wn; logic [31:0] wd;
        logic [31:0] res; logic [3:0] st; logic pwe; logic [31:0] pwd;
        logic chk_res;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
        input logic [31:0] p, input logic [31:0] res, input logic [3:0] st,
        input logic pwe, input logic [31:0] pwd, input logic cr);
        vec_t t;
        t.op = op; t.f3 = f3; t.f7 = f7; t.n1 = 5'd1; t.n2 = 5'd2;
        t.d1 = d1; t.d2 = d2; t.imm = im; t.pc = p;
        t.me = 1'b0; t.mn = 5'd0; t.md = '0;
        t.we = 1'b0; t.wn = 5'd0; t.wd = '0;
        t.res = res; t.st = st; t.pwe = pwe; t.pwd = pwd; t.chk_res = cr;
        return t;
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0; pc = '0; imm = '0;
        opcode = '0; func3 = '0; func7 = '0;
        rs1_num = '0; rs2_num = '0; rd_num = '0;
        rs1_data = '0; rs2_data = '0;
        fwd_mem_en = 1'b0; fwd_mem_num = '0; fwd_mem_data = '0;
        fwd_wb_en = 1'b0; fwd_wb_num = '0; fwd_wb_data = '0;
    endtask

    task automatic drive(input vec_t x, input logic [4:0] rd);
        opcode = x.op; func3 = x.f3; func7 = x.f7;
        rs1_num = x.n1; rs2_num = x.n2; rd_num = rd;
        rs1_data = x.d1; rs2_data = x.d2; imm = x.imm; pc = x.pc;
        fwd_mem_en = x.me; fwd_mem_num = x.mn; fwd_mem_data = x.md;
        fwd_wb_en = x.we; fwd_wb_num = x.wn; fwd_wb_data = x.wd;
    endtask

    task automatic run_md(input string nm, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int n;
        int nb;
        @(negedge clk);
        drive(mk(OPR, f3, 7'h01, a, b, 0, 0, 0, 0, 0, 0, 1), 5'd12);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_busy_on"}, 32'(busy), 32'd1);
        chk({nm, "_in_ready_low"}, 32'(in_ready), 32'd0);
        n = 0;
        nb = busy ? 1 : 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (busy) nb++;
        end
        chk({nm, "_latency"}, 32'(n), 32'd33);
        chk({nm, "_busy_cycles"}, 32'(nb), 32'd32);
        chk({nm, "_result"}, out_result, exp);
        chk({nm, "_state"}, 32'(out_state), 32'd1);
        chk({nm, "_rd"}, 32'(out_rd_num), 32'd12);
    endtask

    vec_t v[$];
    vec_t t;
    int rises;

    initial begin
        // addi x5,x0,7 : rs1_data ignored because x0 reads zero
        t = mk(OPI, 0, 0, 32'h55, 0, 7, 0, 7, 1, 0, 0, 1);
        t.n1 = 0; v.push_back(t);
        t = mk(OPR, 0, 0, 1, 1, 0, 0, 14, 1, 0, 0, 1);
        t.n1 = 5; t.n2 = 5; t.me = 1; t.mn = 5; t.md = 7; v.push_back(t);
        t.we = 1; t.wn = 5; t.wd = 99; v.push_back(t);
        t = mk(OPR, 0, 7'h20, 0, 3, 0, 0, 47, 1, 0, 0, 1);
        t.n1 = 5; t.n2 = 6; t.we = 1; t.wn = 5; t.wd = 50; v.push_back(t);
        t = mk(OPR, 0, 0, 32'h44, 9, 0, 0, 9, 1, 0, 0, 1);
        t.n1 = 0; t.me = 1; t.mn = 0; t.md = 77; v.push_back(t);
        v.push_back(mk(OPR, 5, 7'h20, 32'h80000000, 32'h24, 0, 0,
                       32'hF8000000, 1, 0, 0, 1));
        v.push_back(mk(OPI, 5, 0, 32'h80000000, 0, 32'h404, 0,
                       32'hF8000000, 1, 0, 0, 1));
        v.push_back(mk(OPI, 5, 0, 32'h80000000, 0, 4, 0,
                       32'h08000000, 1, 0, 0, 1));
        v.push_back(mk(OPR, 2, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 1, 0, 0, 1));
        v.push_back(mk(OPR, 3, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 0, 0, 1));
        v.push_back(mk(OPR, 7, 0, 32'hF0F0, 32'hFF00, 0, 0, 32'hF000,
                       1, 0, 0, 1));
        v.push_back(mk(OPR, 1, 0, 3, 4, 0, 0, 32'h30, 1, 0, 0, 1));
        v.push_back(mk(LD, 2, 0, 32'h1000, 0, 32'hFFFFFFFC, 0, 32'hFFC,
                       2, 0, 0, 1));
        v.push_back(mk(STO, 2, 0, 32'h2000, 32'hDEAD, 8, 0, 32'h2008,
                       3, 0, 0, 1));
        v.push_back(mk(BR, 0, 0, 3, 3, 16, 32'h100, 0, 4, 1, 32'h110, 0));
        v.push_back(mk(BR, 0, 0, 3, 4, 16, 32'h100, 0, 0, 0, 0, 0));
        v.push_back(mk(BR, 4, 0, 32'hFFFFFFFB, 2, 32'hFFFFFFF8, 32'h200,
                       0, 4, 1, 32'h1F8, 0));
        v.push_back(mk(BR, 7, 0, 1, 32'hFFFFFFFF, 16, 32'h200, 0,
                       0, 0, 0, 0));
        v.push_back(mk(JAL, 0, 0, 0, 0, 32'h40, 32'h300, 32'h304,
                       5, 1, 32'h340, 1));
        v.push_back(mk(JALR, 0, 0, 32'h1001, 0, 4, 32'h400, 32'h404,
                       5, 1, 32'h1004, 1));
        v.push_back(mk(LUI, 0, 0, 0, 0, 32'h12345000, 0, 32'h12345000,
                       6, 0, 0, 1));
        v.push_back(mk(AUIPC, 0, 0, 0, 0, 32'h2000, 32'h1000, 32'h3000,
                       1, 0, 0, 1));

        idle_inputs();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_state", 32'(out_state), 0);
        chk("rst_pc_we", 32'(pc_write_enable), 0);
        chk("rst_pc_wd", pc_write_data, 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        reset = 1'b1;

        foreach (v[i]) begin
            @(negedge clk);
            drive(v[i], 5'(i + 1));
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
            if (v[i].chk_res)
                chk($sformatf("vec%0d_res", i), out_result, v[i].res);
            chk($sformatf("vec%0d_state", i), 32'(out_state), 32'(v[i].st));
            chk($sformatf("vec%0d_rd", i), 32'(out_rd_num), 32'(i + 1));
            chk($sformatf("vec%0d_f3", i), 32'(out_func3), 32'(v[i].f3));
            chk($sformatf("vec%0d_pwe", i), 32'(pc_write_enable),
                32'(v[i].pwe));
            if (v[i].op == STO)
                chk($sformatf("vec%0d_sd", i), out_store_data, v[i].d2);
            if (v[i].pwe) begin
                chk($sformatf("vec%0d_pwd", i), pc_write_data, v[i].pwd);
                @(posedge clk); #1;
                chk($sformatf("vec%0d_pulse_end", i),
                    32'(pc_write_enable), 0);
            end
        end

        run_md("mul", 3'd0, 32'hFFFFFFFF, 2, 32'hFFFFFFFE);
        run_md("mulhu", 3'd3, 32'hFFFFFFFF, 2, 32'h00000001);
        run_md("mulh", 3'd1, 32'hFFFFFFFF, 2, 32'hFFFFFFFF);
        run_md("div0", 3'd4, 10, 0, 32'hFFFFFFFF);
        run_md("rem0", 3'd6, 10, 0, 10);
        run_md("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_md("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 0);
        run_md("divu", 3'd5, 100, 7, 14);
        run_md("remneg", 3'd6, 32'hFFFFFFF9, 2, 32'hFFFFFFFF);
        run_md("divneg", 3'd4, 32'hFFFFFFF9, 2, 32'hFFFFFFFD);

        // backpressure: held output, then same-cycle accept on release
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        drive(mk(OPR, 0, 0, 2, 3, 0, 0, 0, 0, 0, 0, 1), 5'd3);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp_first_valid", 32'(out_valid), 1);
        chk("bp_first_res", out_result, 5);
        drive(mk(OPR, 0, 0, 10, 20, 0, 0, 0, 0, 0, 0, 1), 5'd9);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 0);
            chk($sformatf("bp_hold%0d_res", k), out_result, 5);
            chk($sformatf("bp_hold%0d_rd", k), 32'(out_rd_num), 3);
            chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_res", out_result, 30);
        chk("bp_second_rd", 32'(out_rd_num), 9);
        chk("bp_second_valid", 32'(out_valid), 1);

        // flush at cycle 10 of a divide
        @(negedge clk);
        drive(mk(OPR, 4, 7'h01, 100, 7, 0, 0, 0, 0, 0, 0, 1), 5'd4);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 0);
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        rises = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        chk("flush_no_result", 32'(rises), 0);

        // flush suppresses a same-cycle accept
        @(negedge clk);
        drive(mk(OPR, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1), 5'd5);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_accept_valid", 32'(out_valid), 0);

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        drive(mk(OPR, 4, 7'h01, 100, 7, 0, 0, 0, 0, 0, 0, 1), 5'd4);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_result", out_result, 0);
        chk("arst_state", 32'(out_state), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        drive(mk(OPR, 0, 0, 4, 5, 0, 0, 0, 0, 0, 0, 1), 5'd6);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_res", out_result, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
